// File: rtl/clk_div_gen_pkg.sv
// Shared types and helpers for the clk_div_gen programmable clock divider.
// Optional feature macro: CLKDIV_DUTY_EN (programmable high time).
package clk_div_gen_pkg;

    // Internal width for ratio/high-time values. Channels zero-extend their
    // CNT_W-wide counters to this width, so CNT_W must not exceed CFG_W.
    localparam int CFG_W = 16;

    // Smallest divide ratio the channels will run at.
    localparam logic [CFG_W-1:0] DIV_MIN = CFG_W'(2);

    // One channel's configuration: the shadow copy loaded over the cfg port.
    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] high;
        logic             pending;
    } ch_cfg_t;

    // Ratios below DIV_MIN cannot produce a toggling output, so raise them.
    function automatic logic [CFG_W-1:0] clamp_div(input logic [CFG_W-1:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

    // Default high time: half the period, rounded down (odd ratios get the
    // shorter high phase).
    function automatic logic [CFG_W-1:0] default_high(input logic [CFG_W-1:0] d);
        return d >> 1;
    endfunction

    // Programmed high time limited to 1..d-1 so the output always toggles.
    function automatic logic [CFG_W-1:0] clamp_high(input logic [CFG_W-1:0] h,
                                                     input logic [CFG_W-1:0] d);
        logic [CFG_W-1:0] v;
        v = (h == '0) ? CFG_W'(1) : h;
        if (v > d - CFG_W'(1)) begin
            v = d - CFG_W'(1);
        end
        return v;
    endfunction

endpackage

// File: rtl/clk_div_gen_ch.sv
// One divider channel: period counter, shadow config register and the
// registered divided-clock / tick outputs.
// Optional feature macro: CLKDIV_DUTY_EN adds the i_high input.
module clk_div_ch
    import clk_div_gen_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DIV_RST = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_div,
`ifdef CLKDIV_DUTY_EN
    input  logic [CNT_W-1:0] i_high,
`endif
    output logic             o_pending,
    output logic             o_div_clk,
    output logic             o_tick
);

    localparam logic [CFG_W-1:0] RST_DIV  = CFG_W'(DIV_RST);
    localparam logic [CFG_W-1:0] RST_HIGH = CFG_W'(DIV_RST / 2);

    // Active ratio / high time and the position within the current period.
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic [CFG_W-1:0] r_div;
    logic [CFG_W-1:0] r_high;
    ch_cfg_t          r_cfg;
    logic             r_div_clk;
    logic             r_tick;

    logic             w_wrap;
    logic             w_restart;
    logic             w_apply;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CFG_W-1:0] w_high_use;
    logic [CFG_W-1:0] w_new_div;
    logic [CFG_W-1:0] w_new_high;

    // Period boundary detection, shadow-apply decision and next-count.
    always_comb begin
        w_wrap     = r_run && (CFG_W'(r_cnt) == (r_div - CFG_W'(1)));
        // A channel that was idle on the previous edge starts at phase 0.
        w_restart  = !r_run || i_sync || w_wrap;
        // Shadows land on a period boundary, or straight away when idle.
        w_apply    = r_cfg.pending && (!i_en || i_sync || w_wrap);
        w_cnt_next = w_restart ? '0 : (r_cnt + 1'b1);
        // The new period must already use the freshly applied high time.
        w_high_use = w_apply ? r_cfg.high : r_high;
        w_new_div  = clamp_div(CFG_W'(i_div));
`ifdef CLKDIV_DUTY_EN
        w_new_high = clamp_high(CFG_W'(i_high), w_new_div);
`else
        w_new_high = default_high(w_new_div);
`endif
    end

    // Counter, active configuration and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_run     <= 1'b0;
            r_div     <= RST_DIV;
            r_high    <= RST_HIGH;
            r_div_clk <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            if (w_apply) begin
                r_div  <= r_cfg.div;
                r_high <= r_cfg.high;
            end
            if (i_en) begin
                r_cnt     <= w_cnt_next;
                r_run     <= 1'b1;
                r_div_clk <= (CFG_W'(w_cnt_next) < w_high_use);
                r_tick    <= (w_cnt_next == '0);
            end else begin
                r_cnt     <= '0;
                r_run     <= 1'b0;
                r_div_clk <= 1'b0;
                r_tick    <= 1'b0;
            end
        end
    end

    // Shadow register: written by the cfg port, pending cleared on apply.
    // A write and an apply never coincide because writes need pending=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg.div     <= RST_DIV;
            r_cfg.high    <= RST_HIGH;
            r_cfg.pending <= 1'b0;
        end else if (i_wr) begin
            r_cfg.div     <= w_new_div;
            r_cfg.high    <= w_new_high;
            r_cfg.pending <= 1'b1;
        end else if (w_apply) begin
            r_cfg.pending <= 1'b0;
        end
    end

    assign o_pending = r_cfg.pending;
    assign o_div_clk = r_div_clk;
    assign o_tick    = r_tick;

endmodule

// File: rtl/clk_div_gen.sv
// N-channel programmable clock divider. Top level decodes config writes,
// muxes cfg_ready from the addressed channel and fans sync_i out.
// Optional feature macro: CLKDIV_DUTY_EN adds cfg_high (programmable high time).
module clk_div_gen
    import clk_div_gen_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int CNT_W   = 8,
    parameter  int DIV_RST = 2,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_i,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLKDIV_DUTY_EN
    input  logic [CNT_W-1:0]  cfg_high,
`endif
    output logic [NUM_CH-1:0] div_clk_o,
    output logic [NUM_CH-1:0] tick_o
);

    localparam int CH_SPAN = 2 ** CH_W;

    logic [NUM_CH-1:0]  w_pending;
    logic [NUM_CH-1:0]  w_wr;
    logic [CH_SPAN-1:0] w_pend_ext;

    // Addresses beyond the last channel read as "not pending", so writes to
    // them are accepted and simply go nowhere.
    for (genvar gi = 0; gi < CH_SPAN; gi++) begin : g_pend
        if (gi < NUM_CH) begin : g_real
            assign w_pend_ext[gi] = w_pending[gi];
        end else begin : g_none
            assign w_pend_ext[gi] = 1'b0;
        end
    end

    assign cfg_ready = ~w_pend_ext[cfg_ch];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign w_wr[gi] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(gi));

        clk_div_ch #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_en      (ch_en[gi]),
            .i_sync    (sync_i),
            .i_wr      (w_wr[gi]),
            .i_div     (cfg_div),
`ifdef CLKDIV_DUTY_EN
            .i_high    (cfg_high),
`endif
            .o_pending (w_pending[gi]),
            .o_div_clk (div_clk_o[gi]),
            .o_tick    (tick_o[gi])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed scenarios followed by random
// enables, syncs and config writes, compared every cycle to a phase model.
// Honours CLKDIV_DUTY_EN when defined.
module tb_clk_div_gen;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [NCH-1:0] ch_en = '0;
    logic           sync_i = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch = '0;
    logic [CW-1:0]  cfg_div = '0;
`ifdef CLKDIV_DUTY_EN
    logic [CW-1:0]  cfg_high = '0;
`endif
    logic [NCH-1:0] div_clk_o;
    logic [NCH-1:0] tick_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    clk_div_gen #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .DIV_RST (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_en     (ch_en),
        .sync_i    (sync_i),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
`ifdef CLKDIV_DUTY_EN
        .cfg_high  (cfg_high),
`endif
        .div_clk_o (div_clk_o),
        .tick_o    (tick_o)
    );

    // Reference model: each channel is a phase within a period of m_div
    // cycles, high while phase < m_high; shadow values wait in m_s*.
    int m_ph   [NCH];
    int m_run  [NCH];
    int m_div  [NCH];
    int m_high [NCH];
    int m_pend [NCH];
    int m_sdiv [NCH];
    int m_shigh[NCH];
    int m_clk  [NCH];
    int m_tick [NCH];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_ph[c] = 0; m_run[c] = 0; m_div[c] = 2; m_high[c] = 1;
            m_pend[c] = 0; m_sdiv[c] = 2; m_shigh[c] = 1;
            m_clk[c] = 0; m_tick[c] = 0;
        end
    endtask

`ifdef CLKDIV_DUTY_EN
    function automatic int want_high(input int d, input int h);
        int v;
        v = (h < 1) ? 1 : h;
        if (v > d - 1) v = d - 1;
        return v;
    endfunction
`else
    function automatic int want_high(input int d);
        return d / 2;
    endfunction
`endif

    function automatic int model_ready();
        int ci;
        ci = int'(cfg_ch);
        if (ci >= NCH) return 1;
        return (m_pend[ci] == 0) ? 1 : 0;
    endfunction

    // Advance the model by one reference-clock edge using current inputs.
    task automatic model_edge();
        int ci;
        int wr_ok;
        int nph;
        int at_end;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ci    = int'(cfg_ch);
        wr_ok = (cfg_valid && model_ready() == 1) ? 1 : 0;
        for (int c = 0; c < NCH; c++) begin
            at_end = (m_run[c] != 0 && m_ph[c] == m_div[c] - 1) ? 1 : 0;
            if (!ch_en[c]) begin
                if (m_pend[c] != 0) begin
                    m_div[c] = m_sdiv[c]; m_high[c] = m_shigh[c]; m_pend[c] = 0;
                end
                m_ph[c] = 0; m_run[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
            end else begin
                nph = (m_run[c] == 0 || sync_i) ? 0 : (m_ph[c] + 1) % m_div[c];
                if (m_pend[c] != 0 && (sync_i || at_end != 0)) begin
                    m_div[c] = m_sdiv[c]; m_high[c] = m_shigh[c]; m_pend[c] = 0;
                end
                m_ph[c]   = nph;
                m_run[c]  = 1;
                m_clk[c]  = (m_ph[c] < m_high[c]) ? 1 : 0;
                m_tick[c] = (m_ph[c] == 0) ? 1 : 0;
            end
            if (wr_ok != 0 && ci == c) begin
                m_sdiv[c] = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
`ifdef CLKDIV_DUTY_EN
                m_shigh[c] = want_high(m_sdiv[c], int'(cfg_high));
`else
                m_shigh[c] = want_high(m_sdiv[c]);
`endif
                m_pend[c] = 1;
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NCH; c++) begin
            check_val($sformatf("div_clk[%0d]", c), int'(div_clk_o[c]), m_clk[c]);
            check_val($sformatf("tick[%0d]", c), int'(tick_o[c]), m_tick[c]);
        end
        check_val("cfg_ready", int'(cfg_ready), model_ready());
    endtask

    // One reference cycle: model on the rising edge, compare on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        $display("cyc t=%0t en=%b sync=%b wr=%b ch=%0d div=%0d | clk=%b tick=%b rdy=%b",
                 $time, ch_en, sync_i, cfg_valid, cfg_ch, cfg_div, div_clk_o, tick_o, cfg_ready);
    endtask

    // Hold a write until the model says it is accepted (bounded).
    task automatic do_write(input int ch, input int div);
        int acc;
        int done;
        done      = 0;
        cfg_ch    = CHW'(ch);
        cfg_div   = CW'(div);
        cfg_valid = 1'b1;
        for (int k = 0; k < 600; k++) begin
            acc = model_ready();
            cyc();
            if (acc != 0) begin
                done = 1;
                break;
            end
        end
        cfg_valid = 1'b0;
        if (done == 0) check_val("write_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int ch);
        int ok;
        ok = 0;
        for (int k = 0; k < 600; k++) begin
            if (m_pend[ch] == 0) begin
                ok = 1;
                break;
            end
            cyc();
        end
        if (ok == 0) check_val("idle_timeout", 0, 1);
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (2) cyc();

        // Default div=2 on channels 0 and 1.
        ch_en = 3'b011;
        repeat (9) cyc();

        // Mid-period ratio change on ch1; cfg_ch stays on 1 so ready is watched.
        do_write(1, 4);
        repeat (12) cyc();

        // Odd ratio on ch0, then programmed high times when enabled.
        do_write(0, 5);
        repeat (12) cyc();
`ifdef CLKDIV_DUTY_EN
        cfg_high = 8'd4;
        do_write(0, 5);
        repeat (12) cyc();
        cfg_high = 8'd9;
        do_write(0, 5);
        repeat (12) cyc();
        cfg_high = 8'd0;
        do_write(0, 5);
        repeat (12) cyc();
`endif

        // Ratio clamp while ch2 is idle, then run it.
        do_write(2, 0);
        cyc();
        ch_en = 3'b111;
        repeat (6) cyc();
        do_write(2, 1);
        repeat (8) cyc();

        // Out-of-range address: accepted, nothing changes.
        do_write(3, 7);
        repeat (6) cyc();

        // Sync at an arbitrary phase: all channels tick together.
        do_write(1, 3);
        cyc();
        sync_i = 1'b1;
        cyc();
        check_val("sync_align", int'(tick_o), 7);
        sync_i = 1'b0;
        repeat (15) cyc();

        // Random traffic.
        for (int n = 0; n < 700; n++) begin
            for (int c = 0; c < NCH; c++) ch_en[c] = ($urandom_range(0, 9) != 0);
            sync_i    = ($urandom_range(0, 29) == 0);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch    = CHW'($urandom_range(0, 3));
            cfg_div   = ($urandom_range(0, 15) == 0) ? CW'($urandom_range(0, 255))
                                                     : CW'($urandom_range(0, 9));
`ifdef CLKDIV_DUTY_EN
            cfg_high  = CW'($urandom_range(0, 12));
`endif
            cyc();
        end
        cfg_valid = 1'b0;
        sync_i    = 1'b0;

        // Asynchronous reset mid-period with a write pending on ch1.
        ch_en = 3'b111;
        cyc();
        wait_idle(1);
        cfg_ch    = 2'd1;
        cfg_div   = 8'd6;
        cfg_valid = 1'b1;
        sync_i    = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        sync_i    = 1'b0;
        check_val("pre_rst_tick", int'(tick_o), 7);
        check_val("pre_rst_pending", int'(cfg_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_div_clk", int'(div_clk_o), 0);
        check_val("rst_tick", int'(tick_o), 0);
        check_val("rst_ready", int'(cfg_ready), 1);
        $display("async reset t=%0t clk=%b tick=%b rdy=%b", $time, div_clk_o, tick_o, cfg_ready);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (10) cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
